// File: rtl/fork_ctrl_pkg.sv
// Shared types and constants for the fork/broadcast controller.
package fork_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, FWD, BCAST, BACKOFF} fork_state_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/fork_delay_cnt.sv
// Loadable down-counter with a zero flag; one instance times both the
// forward-latency and backoff waits.
module fork_delay_cnt
  import fork_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_en && (r_cnt != '0))  r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fork_broadcast_ctrl.sv
// Captures one token from a valid/ready producer and holds it until every
// consumer has taken it, with forward-latency and backoff gaps.
module fork_broadcast_ctrl
  import fork_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NOUT  = 2,
  parameter int FL    = 2,
  parameter int BL    = 8,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [NOUT-1:0]  out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [NOUT-1:0]  out_ready,
  output logic             busy,
  output logic [CW-1:0]    tok_count
);

  // Counter preloads are one less than the wait because the transition
  // edge itself counts as the last cycle of the wait.
  localparam logic [CNT_W-1:0] FL_LD = (FL > 0) ? CNT_W'(FL - 1) : '0;
  localparam logic [CNT_W-1:0] BL_LD = (BL > 0) ? CNT_W'(BL - 1) : '0;

  fork_state_t      r_state, w_nxt;
  logic [WIDTH-1:0] r_data;
  logic [NOUT-1:0]  r_served;
  logic [CW-1:0]    r_tok;

  logic [NOUT-1:0]  w_vld, w_srv_nxt;
  logic             w_ld, w_en, w_zero, w_cap, w_done;
  logic [CNT_W-1:0] w_ld_val;

  fork_delay_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  assign w_vld     = (r_state == BCAST) ? ~r_served : '0;
  assign w_srv_nxt = r_served | (w_vld & out_ready);

  always_comb begin
    w_nxt    = r_state;
    w_ld     = 1'b0;
    w_ld_val = '0;
    w_en     = 1'b0;
    w_cap    = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: if (in_valid) begin
        w_cap = 1'b1;
        if (FL == 0) w_nxt = BCAST;
        else begin
          w_nxt    = FWD;
          w_ld     = 1'b1;
          w_ld_val = FL_LD;
        end
      end
      FWD: begin
        if (w_zero) w_nxt = BCAST;
        else        w_en  = 1'b1;
      end
      // Completion counts acceptances landing on this same edge.
      BCAST: if (&w_srv_nxt) begin
        w_done = 1'b1;
        if (BL == 0) w_nxt = IDLE;
        else begin
          w_nxt    = BACKOFF;
          w_ld     = 1'b1;
          w_ld_val = BL_LD;
        end
      end
      BACKOFF: begin
        if (w_zero) w_nxt = IDLE;
        else        w_en  = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_served <= '0;
      r_tok    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_cap) begin
        r_data   <= in_data;
        r_served <= '0;
      end else if (r_state == BCAST) begin
        r_served <= w_srv_nxt;
      end
      if (w_done) r_tok <= r_tok + 1'b1;
    end
  end

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = w_vld;
  assign out_data  = r_data;
  assign busy      = (r_state != IDLE);
  assign tok_count = r_tok;

endmodule

// File: tb/tb_fork_broadcast_ctrl.sv
// Drives two controller configurations with shared stimulus and compares
// every cycle against a transaction-timing reference model.
module tb_fork_broadcast_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] ordy = '0;

  always #5 clk = ~clk;

  logic        rdy0, busy0, rdy1, busy1;
  logic [1:0]  vld0;
  logic [2:0]  vld1;
  logic [7:0]  dat0, dat1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  fork_broadcast_ctrl #(.WIDTH(8), .NOUT(2), .FL(2), .BL(8), .CW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(vld0), .out_data(dat0), .out_ready(ordy[1:0]),
    .busy(busy0), .tok_count(cnt0));

  fork_broadcast_ctrl #(.WIDTH(8), .NOUT(3), .FL(0), .BL(0), .CW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(vld1), .out_data(dat1), .out_ready(ordy),
    .busy(busy1), .tok_count(cnt1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] @%0t: got %0h expected %0h", tag, id, $time, act, exp);
    end
  endtask

  // Reference model: a token is described by its capture edge and the edge
  // from which the producer may be served again; everything else follows.
  int         now = 0;
  int         cap_at[2];
  int         rdy_at[2];
  bit         infl[2];
  logic [7:0] mdat[2];
  logic [2:0] srv[2];
  int         tok[2];

  function automatic int fl(input int id);    return id ? 0 : 2; endfunction
  function automatic int bl(input int id);    return id ? 0 : 8; endfunction
  function automatic logic [2:0] allm(input int id); return id ? 3'b111 : 3'b011; endfunction
  function automatic logic [31:0] tmask(input int id); return id ? 32'hF : 32'hFFFF; endfunction

  function automatic logic exp_rdy(input int id);
    return !infl[id] && (now >= rdy_at[id]);
  endfunction
  function automatic logic [2:0] exp_vld(input int id);
    if (infl[id] && (now >= cap_at[id] + fl(id))) return allm(id) & ~srv[id];
    return 3'b000;
  endfunction
  function automatic logic exp_busy(input int id);
    return infl[id] || (now < rdy_at[id]);
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      infl[id] = 0; rdy_at[id] = now; cap_at[id] = 0;
      mdat[id] = '0; srv[id] = '0; tok[id] = 0;
    end
  endtask

  task automatic check_all();
    chk("in_ready",  0, {31'b0, rdy0},  {31'b0, exp_rdy(0)});
    chk("out_valid", 0, {30'b0, vld0},  {29'b0, exp_vld(0)});
    chk("out_data",  0, {24'b0, dat0},  {24'b0, mdat[0]});
    chk("busy",      0, {31'b0, busy0}, {31'b0, exp_busy(0)});
    chk("tok_count", 0, {16'b0, cnt0},  tok[0] & tmask(0));
    chk("in_ready",  1, {31'b0, rdy1},  {31'b0, exp_rdy(1)});
    chk("out_valid", 1, {29'b0, vld1},  {29'b0, exp_vld(1)});
    chk("out_data",  1, {24'b0, dat1},  {24'b0, mdat[1]});
    chk("busy",      1, {31'b0, busy1}, {31'b0, exp_busy(1)});
    chk("tok_count", 1, {28'b0, cnt1},  tok[1] & tmask(1));
  endtask

  task automatic step_model();
    for (int id = 0; id < 2; id++) begin
      if (exp_rdy(id) && in_valid) begin
        infl[id] = 1; cap_at[id] = now + 1; mdat[id] = in_data; srv[id] = '0;
      end else if (exp_vld(id) != 3'b000) begin
        srv[id] = srv[id] | (ordy & allm(id));
        if (srv[id] == allm(id)) begin
          infl[id] = 0; rdy_at[id] = now + 1 + bl(id); tok[id]++;
        end
      end
    end
    now++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] r);
    @(negedge clk);
    check_all();
    in_valid = v; in_data = d; ordy = r;
    @(posedge clk);
    step_model();
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", 0, {30'b0, vld0}, 32'd0);
    chk("rst_in_ready",  0, {31'b0, rdy0}, 32'd0);
    chk("rst_out_data",  0, {24'b0, dat0}, 32'd0);
    chk("rst_busy",      0, {31'b0, busy0}, 32'd0);
    chk("rst_tok_count", 0, {16'b0, cnt0}, 32'd0);
    chk("rst_out_valid", 1, {29'b0, vld1}, 32'd0);
    chk("rst_in_ready",  1, {31'b0, rdy1}, 32'd0);
    chk("rst_tok_count", 1, {28'b0, cnt1}, 32'd0);
  endtask

  // Reset asserted between edges so its effect must be asynchronous.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    in_valid = 1'b0; ordy = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1 reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single token, consumers always ready.
    repeat (3) cycle(1'b0, 8'h00, 3'b111);
    cycle(1'b1, 8'h5A, 3'b111);
    repeat (20) cycle(1'b0, 8'h00, 3'b111);
    chk("single_tok", 0, {16'b0, cnt0}, 32'd1);

    // Staggered acceptance, then a new token offered during backoff.
    cycle(1'b1, 8'hA5, 3'b000);
    repeat (2) cycle(1'b0, 8'h00, 3'b000);
    repeat (3) cycle(1'b0, 8'h00, 3'b001);
    cycle(1'b0, 8'h00, 3'b111);
    repeat (12) cycle(1'b1, 8'hFF, 3'b111);
    repeat (4) cycle(1'b0, 8'h00, 3'b111);

    // Back-to-back tokens.
    for (int k = 1; k <= 4; k++) repeat (2) cycle(1'b1, 8'(k), 3'b111);
    repeat (12) cycle(1'b0, 8'h00, 3'b111);

    // Reset while u0 is broadcasting with output 0 already served.
    cycle(1'b1, 8'h33, 3'b000);
    repeat (2) cycle(1'b0, 8'h00, 3'b000);
    cycle(1'b0, 8'h00, 3'b001);
    pulse_reset();
    cycle(1'b0, 8'h00, 3'b000);
    chk("post_rst_rdy", 0, {31'b0, rdy0}, 32'd1);

    // Randomised traffic; u1 wraps its 4-bit counter several times.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] r;
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      cycle(1'($urandom), 8'($urandom), r);
    end
    cycle(1'b0, 8'h00, 3'b111);
    chk("wrap_seen", 1, {31'b0, (tok[1] > 16)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
